// File: rtl/shift_pkg.sv
// Shared types and defaults for the serial-to-parallel frame path.
package shift_pkg;

    localparam int unsigned DEFAULT_WIDTH = 256;

    typedef enum logic [0:0] {
        FILLING = 1'b0,
        FULL    = 1'b1
    } fill_state_e;

endpackage

// File: rtl/frame_holding_reg.sv
// Output stage: holds one completed frame until the consumer takes it.
module frame_holding_reg #(
    parameter int unsigned WIDTH = shift_pkg::DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             p_ready,
    output logic [WIDTH-1:0] p_out,
    output logic             p_valid
);

    logic [WIDTH-1:0] p_out_q;
    logic [WIDTH-1:0] p_out_d;
    logic             p_valid_q;
    logic             p_valid_d;

    // A load always wins; otherwise a handshake empties the stage.
    always_comb begin
        p_out_d   = p_out_q;
        p_valid_d = p_valid_q;
        if (load) begin
            p_out_d   = load_data;
            p_valid_d = 1'b1;
        end else if (p_valid_q && p_ready) begin
            p_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            p_out_q   <= '0;
            p_valid_q <= 1'b0;
        end else begin
            p_out_q   <= p_out_d;
            p_valid_q <= p_valid_d;
        end
    end

    assign p_out   = p_out_q;
    assign p_valid = p_valid_q;

endmodule

// File: rtl/frame_deserializer.sv
// Serial-to-parallel frame assembler with a one-frame output buffer,
// backpressure via s_ready and a sticky overrun flag.
module frame_deserializer
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH     = DEFAULT_WIDTH,
    parameter int unsigned MSB_FIRST = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       shift,
    input  logic                       s_in,
    output logic                       s_ready,
    input  logic                       clear,
    output logic [WIDTH-1:0]           p_out,
    output logic                       p_valid,
    input  logic                       p_ready,
    output logic [$clog2(WIDTH+1)-1:0] bit_count,
    output logic                       overrun
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    fill_state_e      state_q;
    fill_state_e      state_d;
    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] sr_d;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_d;
    logic             overrun_q;
    logic             overrun_d;

    logic [WIDTH-1:0] sr_shift;
    logic             hold_free;
    logic             load;
    logic [WIDTH-1:0] load_data;

    always_comb begin
        if (MSB_FIRST != 0) begin
            sr_shift = {sr_q[WIDTH-2:0], s_in};
        end else begin
            sr_shift = {s_in, sr_q[WIDTH-1:1]};
        end
    end

    // Output stage can accept a frame this cycle if empty or being drained.
    assign hold_free = !p_valid || p_ready;

    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        cnt_d     = cnt_q;
        overrun_d = overrun_q;
        load      = 1'b0;
        load_data = sr_q;

        if (clear) begin
            state_d   = FILLING;
            sr_d      = '0;
            cnt_d     = '0;
            overrun_d = 1'b0;
        end else begin
            unique case (state_q)
                FILLING: begin
                    if (shift) begin
                        sr_d = sr_shift;
                        if (cnt_q == CW'(WIDTH - 1)) begin
                            if (hold_free) begin
                                load      = 1'b1;
                                load_data = sr_shift;
                                cnt_d     = '0;
                            end else begin
                                cnt_d   = CW'(WIDTH);
                                state_d = FULL;
                            end
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                end
                FULL: begin
                    if (shift) begin
                        overrun_d = 1'b1;
                    end
                    // Refill the output stage in the same cycle it drains.
                    if (p_valid && p_ready) begin
                        load      = 1'b1;
                        load_data = sr_q;
                        cnt_d     = '0;
                        state_d   = FILLING;
                    end
                end
                default: state_d = FILLING;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= FILLING;
            sr_q      <= '0;
            cnt_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            cnt_q     <= cnt_d;
            overrun_q <= overrun_d;
        end
    end

    frame_holding_reg #(
        .WIDTH(WIDTH)
    ) u_hold (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .load_data(load_data),
        .p_ready  (p_ready),
        .p_out    (p_out),
        .p_valid  (p_valid)
    );

    assign s_ready   = (state_q == FILLING);
    assign bit_count = cnt_q;
    assign overrun   = overrun_q;

endmodule
